// File: rtl/mem_resp_pkg.sv
// Shared constants for the core data-memory responder: FSM encoding and the
// width of the read-latency counter.
package mem_resp_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] S_ACCESS  = 2'd1;
  localparam logic [STATE_W-1:0] S_WAITRD  = 2'd2;
  localparam logic [STATE_W-1:0] S_RESPOND = 2'd3;

  // READ_LATENCY is legal in 1..7, so the counter never holds more than 6.
  localparam int MAX_READ_LATENCY = 7;
  localparam int CNT_W            = $clog2(MAX_READ_LATENCY + 1);

  // Counter preload for a given read latency: WAITRD exits when it hits 0.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/core_mem_responder_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int CORES = 4,
  parameter int IDX_W = 2
) (
  input  logic [CORES-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int off = CORES - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % CORES]) grant = IDX_W'((int'(ptr) + off) % CORES);
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder: arbitrates core data requests round-robin onto one
// single-port synchronous RAM, one access at a time, and returns a one-cycle
// one-hot response pulse (with read data) to the served core.
module core_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int CORES        = 4,
  parameter int IDX_W        = 2,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 2   // 1..7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CORES-1:0]       request,
  input  logic [CORES-1:0]       wren,
  input  logic [CORES*WIDTH-1:0] address,
  input  logic [CORES*WIDTH-1:0] writedata,
  output logic [CORES-1:0]       response,
  output logic [WIDTH-1:0]       readdata,
  output logic [ADDR_WIDTH-1:0]  ram_addr,
  output logic                   ram_we,
  output logic [WIDTH-1:0]       ram_wdata,
  input  logic [WIDTH-1:0]       ram_rdata,
  output logic                   busy
);

  logic [STATE_W-1:0] state;
  logic [IDX_W-1:0]   g_idx;     // core being served
  logic [IDX_W-1:0]   rr_ptr;    // highest-priority core for the next grant
  logic [IDX_W-1:0]   arb_grant;
  logic               arb_any;
  logic               we_q;      // latched direction of the current access
  logic [CNT_W-1:0]   cnt;

  rr_arbiter #(
    .CORES (CORES),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (request),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  // Transaction FSM; every output is a register so cores and RAM see clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      g_idx     <= '0;
      rr_ptr    <= '0;
      we_q      <= 1'b0;
      cnt       <= '0;
      response  <= '0;
      readdata  <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Only the values latched here are used for the rest of the access.
          if (arb_any) begin
            g_idx     <= arb_grant;
            ram_addr  <= address[int'(arb_grant)*WIDTH +: ADDR_WIDTH];
            ram_wdata <= writedata[int'(arb_grant)*WIDTH +: WIDTH];
            we_q      <= wren[arb_grant];
            ram_we    <= wren[arb_grant];
            busy      <= 1'b1;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // The write strobe lives for exactly this one cycle.
          ram_we <= 1'b0;
          if (we_q) begin
            response <= CORES'(1) << g_idx;
            state    <= S_RESPOND;
          end else begin
            cnt   <= lat_load(READ_LATENCY);
            state <= S_WAITRD;
          end
        end
        S_WAITRD: begin
          // Counter reaches 0 in the cycle the RAM presents the read word.
          if (cnt == '0) begin
            readdata <= ram_rdata;
            response <= CORES'(1) << g_idx;
            state    <= S_RESPOND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESPOND: begin
          // Served core drops to lowest priority for the next round.
          response <= '0;
          rr_ptr   <= (int'(g_idx) == CORES - 1) ? '0 : g_idx + IDX_W'(1);
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Bench for core_mem_responder: three instances (read latency 2, 1, 4), each
// with its own behavioural RAM. Directed latency/fairness/reset checks plus
// concurrent random traffic against a shadow memory.
module tb_core_mem_responder;

  localparam int WIDTH = 32;
  localparam int CORES = 4;
  localparam int IDX_W = 2;
  localparam int AW    = 8;
  localparam int NI    = 3;

  function automatic int rl_of(input int v);
    return (v == 0) ? 2 : ((v == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] init_val(input int v, input int a);
    if (a == 16) return 32'hDEADBEEF;
    return ((32'(a) + 32'd1) * 32'h9E3779B9) ^ (32'(v) << 24);
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_init = 1'b1;
  always #5 clk = ~clk;

  logic [CORES-1:0]       request   [NI];
  logic [CORES-1:0]       wren      [NI];
  logic [CORES*WIDTH-1:0] address   [NI];
  logic [CORES*WIDTH-1:0] writedata [NI];
  logic [CORES-1:0]       response  [NI];
  logic [WIDTH-1:0]       readdata  [NI];
  logic [AW-1:0]          ram_addr  [NI];
  logic                   ram_we    [NI];
  logic [WIDTH-1:0]       ram_wdata [NI];
  logic [WIDTH-1:0]       ram_rdata [NI];
  logic                   busy      [NI];

  logic [31:0] ref_mem [NI][256];
  logic [31:0] last_rd [NI];
  int          order_q [$];
  int          n_chk  = 0;
  int          n_fail = 0;

  for (genvar v = 0; v < NI; v++) begin : g_dut
    localparam int RL = rl_of(v);
    logic [WIDTH-1:0] mem  [256];
    logic [WIDTH-1:0] pipe [RL];

    core_mem_responder #(
      .WIDTH(WIDTH), .CORES(CORES), .IDX_W(IDX_W),
      .ADDR_WIDTH(AW), .READ_LATENCY(RL)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .request(request[v]), .wren(wren[v]),
      .address(address[v]), .writedata(writedata[v]),
      .response(response[v]), .readdata(readdata[v]),
      .ram_addr(ram_addr[v]), .ram_we(ram_we[v]),
      .ram_wdata(ram_wdata[v]), .ram_rdata(ram_rdata[v]),
      .busy(busy[v])
    );

    // Synchronous RAM: address sampled each edge, word emerges RL cycles later.
    always @(posedge clk) begin
      if (ram_init) begin
        for (int a = 0; a < 256; a++) mem[a] <= init_val(v, a);
      end else if (ram_we[v]) begin
        mem[ram_addr[v]] <= ram_wdata[v];
      end
      pipe[0] <= mem[ram_addr[v]];
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata[v] = pipe[RL-1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int v = 0; v < NI; v++) begin
      chk($sformatf("%s.resp%0d", tag, v),  32'(response[v]), 0);
      chk($sformatf("%s.rdata%0d", tag, v), readdata[v], 0);
      chk($sformatf("%s.addr%0d", tag, v),  32'(ram_addr[v]), 0);
      chk($sformatf("%s.we%0d", tag, v),    32'(ram_we[v]), 0);
      chk($sformatf("%s.wdata%0d", tag, v), ram_wdata[v], 0);
      chk($sformatf("%s.busy%0d", tag, v),  32'(busy[v]), 0);
    end
  endtask

  // One isolated transaction from an idle responder; checks latency, strobe, data.
  task automatic do_op(input int v, input int k, input bit we,
                       input logic [31:0] addr, input logic [31:0] data, input string tag);
    int c = 0, we_cnt = 0, we_at = -1;
    bit seen = 0;
    logic [31:0] exp;
    wren[v][k] = we;
    address[v][k*WIDTH +: WIDTH]   = addr;
    writedata[v][k*WIDTH +: WIDTH] = data;
    request[v][k] = 1'b1;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      if (ram_we[v]) begin we_cnt++; we_at = c; end
      if (c == 1) chk({tag, ".addr"}, 32'(ram_addr[v]), 32'(addr[AW-1:0]));
      if (response[v] != '0) seen = 1;
    end
    request[v][k] = 1'b0;
    chk({tag, ".resp"}, 32'(response[v]), 32'(1) << k);
    chk({tag, ".lat"}, c, we ? 2 : 2 + rl_of(v));
    chk({tag, ".we_cnt"}, we_cnt, we ? 1 : 0);
    if (we) begin
      chk({tag, ".we_at"}, we_at, 1);
      chk({tag, ".rd_hold"}, readdata[v], last_rd[v]);
      ref_mem[v][addr[AW-1:0]] = data;
    end else begin
      exp = ref_mem[v][addr[AW-1:0]];
      chk({tag, ".rdata"}, readdata[v], exp);
      last_rd[v] = exp;
    end
    @(negedge clk);
    chk({tag, ".resp_clr"}, 32'(response[v]), 0);
    chk({tag, ".idle"}, 32'(busy[v]), 0);
  endtask

  // Several cores read together; pend[k] = how many back-to-back reads core k wants.
  task automatic group(input int v, input int p0, input int p1, input int p2, input int p3);
    int pend [CORES];
    int guard = 0, left;
    pend = '{p0, p1, p2, p3};
    order_q.delete();
    for (int k = 0; k < CORES; k++) begin
      wren[v][k] = 1'b0;
      address[v][k*WIDTH +: WIDTH] = 32'h40 + 32'(k);
      request[v][k] = (pend[k] > 0);
    end
    left = p0 + p1 + p2 + p3;
    while (left > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (response[v] != '0) chk("grp.onehot", 32'($onehot(response[v])), 1);
      for (int k = 0; k < CORES; k++) begin
        if (response[v][k]) begin
          order_q.push_back(k);
          chk($sformatf("grp.rdata%0d", k), readdata[v], ref_mem[v][8'h40 + k]);
          last_rd[v] = ref_mem[v][8'h40 + k];
          pend[k]--;
          left--;
          if (pend[k] == 0) request[v][k] = 1'b0;
        end
      end
    end
    request[v] = '0;
    if (left > 0) chk("grp.timeout", 0, 1);
    @(negedge clk);
  endtask

  // Random traffic on all cores of one instance, checked against the shadow memory.
  task automatic rand_run(input int v, input int ncyc);
    bit          act  [CORES];
    bit          w    [CORES];
    int          cool [CORES];
    int          start[CORES];
    logic [31:0] a    [CORES];
    int served = 0, cyc = 0, nact = 0;
    for (int k = 0; k < CORES; k++) begin act[k] = 0; cool[k] = 0; end
    while ((cyc < ncyc || nact > 0) && cyc < ncyc + 300) begin
      @(negedge clk);
      cyc++;
      if (response[v] != '0) begin
        chk("rnd.onehot", 32'($onehot(response[v])), 1);
        served++;
      end
      for (int k = 0; k < CORES; k++) begin
        if (act[k] && response[v][k]) begin
          if (w[k]) begin
            chk("rnd.wr_hold", readdata[v], last_rd[v]);
            ref_mem[v][a[k][AW-1:0]] = writedata[v][k*WIDTH +: WIDTH];
          end else begin
            chk("rnd.rdata", readdata[v], ref_mem[v][a[k][AW-1:0]]);
            last_rd[v] = ref_mem[v][a[k][AW-1:0]];
          end
          chk("rnd.fair", 32'((served - 1 - start[k]) <= CORES - 1), 1);
          act[k] = 0;
          nact--;
          request[v][k] = 1'b0;
          cool[k] = $urandom_range(0, 3);
        end else if (!act[k] && cyc < ncyc) begin
          if (cool[k] > 0) cool[k]--;
          else if ($urandom_range(0, 1) == 1) begin
            w[k] = 1'($urandom_range(0, 1));
            a[k] = $urandom;
            wren[v][k] = w[k];
            address[v][k*WIDTH +: WIDTH]   = a[k];
            writedata[v][k*WIDTH +: WIDTH] = $urandom;
            request[v][k] = 1'b1;
            start[k] = served;
            act[k] = 1;
            nact++;
          end
        end
      end
    end
    if (nact > 0) chk($sformatf("rnd.drain%0d", v), 32'(nact), 0);
    request[v] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int v = 0; v < NI; v++) begin
      request[v] = '0; wren[v] = '0; address[v] = '0; writedata[v] = '0;
      last_rd[v] = '0;
      for (int a = 0; a < 256; a++) ref_mem[v][a] = init_val(v, a);
    end
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Latency and basic function on each latency variant.
    for (int v = 0; v < NI; v++) begin
      do_op(v, 0, 1'b0, 32'h10, 32'h0, $sformatf("rd10_%0d", v));
      do_op(v, 2, 1'b1, 32'h20, 32'hA5A50001, $sformatf("wr20_%0d", v));
      do_op(v, 2, 1'b0, 32'h20, 32'h0, $sformatf("rd20_%0d", v));
      do_op(v, 3, 1'b0, 32'hABCD0110, 32'h0, $sformatf("alias_%0d", v));
    end

    // Pointer is 0: all four request, core0 re-requests at once.
    group(0, 2, 1, 1, 1);
    chk("fair.n", order_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("fair[%0d]", i), (i < order_q.size()) ? order_q[i] : -1, (i == 4) ? 0 : i);

    // After core3 is served the pointer wraps to core0.
    do_op(0, 3, 1'b0, 32'h33, 32'h0, "pre_wrap");
    group(0, 1, 0, 0, 1);
    chk("wrap.n", order_q.size(), 2);
    chk("wrap[0]", (order_q.size() > 0) ? order_q[0] : -1, 0);
    chk("wrap[1]", (order_q.size() > 1) ? order_q[1] : -1, 3);

    // Reset in the middle of a read; the held request is served afterwards.
    wren[0][1] = 1'b0;
    address[0][1*WIDTH +: WIDTH] = 32'h55;
    request[0][1] = 1'b1;
    repeat (2) @(negedge clk);
    chk("mrst.busy", 32'(busy[0]), 1);
    #1 rst_n = 1'b0;
    #1 check_reset("mrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst.noresp", 32'(response[0]), 0);
    end
    for (int v = 0; v < NI; v++) last_rd[v] = '0;
    rst_n = 1'b1;
    do_op(0, 1, 1'b0, 32'h55, 32'h0, "mrst.reserve");

    // Concurrent random traffic on every instance.
    fork
      rand_run(0, 400);
      rand_run(1, 400);
      rand_run(2, 400);
    join
    @(negedge clk);
    for (int v = 0; v < NI; v++) chk($sformatf("end.busy%0d", v), 32'(busy[v]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
